led_bank_ctrl: RTL
==================

// Module: led_bank_ctrl
// PURPOSE
// - Shares one bank of NumLeds enable-DFF+LED cells (dff_en_led merge cell) between NumReq requesters.
// - Per cycle: at most one SET/CLR/TOGGLE write to one LED, granted round-robin.
// - Also sequences a bank-wide clear sweep, one LED per cycle, which keeps fanout on the shared d line low.
// - Sits between bus/peripheral logic and the LED cell array; drives each cell's en/d and reads back its q.
// PARAMETERS
// - NumLeds  8  number of dff_en_led cells driven; >= 2
// - NumReq   2  number of requesters; >= 1
// - IdxW     $clog2(NumLeds)  LED index width (derived, not overridable)
// PORTS
// - clk_i        in   1             clock; same clock as the LED cells
// - rst_ni       in   1             asynchronous reset, active low
// - req_valid_i  in   NumReq        request valid, one per requester
// - req_ready_o  out  NumReq        request accepted this cycle (at most one bit set)
// - req_idx_i    in   NumReq*IdxW   target LED index per requester
// - req_op_i     in   NumReq*2      op per requester: 0 NOP, 1 SET, 2 CLR, 3 TOGGLE
// - clear_i      in   1             start a clear sweep (level sampled in IDLE)
// - led_en_o     out  NumLeds       per-cell enable (cell en_i)
// - led_d_o      out  NumLeds       per-cell data (cell d_i)
// - led_q_i      in   NumLeds       per-cell readback (cell q_o)
// - busy_o       out  1             sweep in progress
// - err_o        out  1             1-cycle pulse: accepted request had idx >= NumLeds
// BEHAVIOUR
// - Reset:
//   - state=IDLE, rr pointer=0, sweep counter=0, err_o=0.
//   - led_en_o=0, busy_o=0, req_ready_o=0 while rst_ni=0. LED cells keep their own state; no clear on reset.
// - Handshake:
//   - Transfer when req_valid_i[i] & req_ready_o[i].
//   - req_ready_o is combinational: one-hot grant, and only when state==IDLE and clear_i==0.
//   - A valid request must hold its idx/op stable until accepted.
// - Arbitration (round-robin):
//   - Search starts at the rr pointer, which is the index of the requester after the last winner.
//   - The pointer updates only on an accepted transfer and wraps NumReq-1 -> 0.
// - Write path (combinational, zero added latency):
//   - On acceptance, led_en_o[idx]=1 for that cycle.
//   - led_d_o[idx] = 1 for SET, 0 for CLR, ~led_q_i[idx] for TOGGLE.
//   - The cell updates at the next clk_i edge, so the new q is visible 1 cycle after the handshake.
//   - NOP: accepted, no enable, pointer advances.
//   - All non-targeted led_en_o=0. led_d_o of disabled cells = 0.
// - Out-of-range idx (NumLeds not a power of 2):
//   - Request accepted, no write, err_o pulses on the next cycle (registered).
// - FSM IDLE -> CLEAR:
//   - In IDLE with clear_i=1, the sweep has priority over requests (no ready that cycle).
//   - Enter CLEAR with counter=0. busy_o=1 from the next cycle.
// - FSM CLEAR:
//   - Each cycle led_en_o[counter]=1 and led_d_o=0; counter increments.
//   - At counter==NumLeds-1, return to IDLE and reset counter to 0. A sweep takes NumLeds cycles.
//   - clear_i is ignored during CLEAR; no restart.
//   - Requests are stalled (ready=0) and their valids must be held.
// - Reset mid-sweep aborts immediately. LEDs not yet cleared keep their value.
// - Back-to-back writes to the same LED in consecutive cycles: each TOGGLE sees the updated q (net effect is 2 toggles).
// STRUCTURE
// - led_bank_pkg holds:
//   - typedef enum logic [1:0] led_op_e {OP_NOP, OP_SET, OP_CLR, OP_TOG}
//   - typedef enum logic led_state_e {ST_IDLE, ST_CLEAR}
// - Sub-module rr_arbiter (parameter NumReq): req vector + advance strobe -> one-hot grant, owns the rr pointer.
// - Top level holds the FSM, sweep counter, err register and the en/d decode.
// TESTING
// - Reset: hold rst_ni=0 with all valids=1 -> ready=0, led_en_o=0, busy_o=0; release -> req 0 granted first.
// - Contention:
//   - req0 and req1 both SET idx 3, valids held -> grants alternate 0,1,0,1.
//   - led_en_o=8'h08 with d=1 each cycle; q[3]=1 one cycle after the first grant.
// - Toggle: q=8'h00, TOGGLE idx 5 for 3 consecutive cycles -> q[5] = 1,0,1 on successive cycles.
// - Clear:
//   - q=8'hFF, pulse clear_i in IDLE -> busy_o high for 8 cycles.
//   - led_en_o walks 01,02,...,80 with d=0; q=8'h00; a request raised mid-sweep is granted on the first IDLE cycle.
// - Simultaneous: clear_i=1 and req0 valid in the same IDLE cycle -> sweep starts, req0 ready=0 until the sweep ends.
// - Abort/err:
//   - NumLeds=6: request idx 7 -> accepted, no enable, err_o=1 for exactly 1 cycle.
//   - Reset asserted at sweep cycle 3 -> LEDs 3..5 keep their value.

Source files
------------

// File: rtl/led_bank_pkg.sv
// Shared types and helpers for the LED bank controller.
package led_bank_pkg;

  // Write operation carried by each requester.
  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_SET = 2'd1,
    OP_CLR = 2'd2,
    OP_TOG = 2'd3
  } led_op_e;

  // Controller state: idle (serving requests) or sweeping the bank clear.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } led_state_e;

  // Data bit to present to a cell for a given op, given its current q.
  function automatic logic op_data(led_op_e op, logic q);
    logic d;
    case (op)
      OP_SET:  d = 1'b1;
      OP_TOG:  d = ~q;
      default: d = 1'b0;
    endcase
    return d;
  endfunction

  // NOP is accepted like any other op but never enables a cell.
  function automatic logic op_writes(led_op_e op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector. The pointer holds
// the index of the requester after the last winner and moves only on advance_i.
module rr_arbiter #(
  parameter int unsigned  NumReq = 2,
  localparam int unsigned PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              advance_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [PtrW-1:0]   gnt_idx_o
);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            found;

  // Search for the first active request starting at the pointer, wrapping.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (!found && req_i[i] && (i == (32'(ptr_q) + off) % NumReq)) begin
          found     = 1'b1;
          gnt_o[i]  = 1'b1;
          gnt_idx_o = PtrW'(i);
        end
      end
    end
  end

  // Pointer moves to the requester after the winner, wrapping to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      if (32'(gnt_idx_o) == NumReq - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_o + 1'b1;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/led_bank_ctrl.sv
// Shares one bank of enable-DFF LED cells between several requesters. At most
// one SET/CLR/TOGGLE write per cycle is granted round-robin; a clear sweep
// walks the bank one LED per cycle so only one cell is loaded at a time.
module led_bank_ctrl
  import led_bank_pkg::*;
#(
  parameter int unsigned  NumLeds = 8,
  parameter int unsigned  NumReq  = 2,
  localparam int unsigned IdxW    = $clog2(NumLeds),
  localparam int unsigned PtrW    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  input  logic [NumReq*IdxW-1:0] req_idx_i,
  input  logic [NumReq*2-1:0]    req_op_i,
  input  logic                   clear_i,
  output logic [NumLeds-1:0]     led_en_o,
  output logic [NumLeds-1:0]     led_d_o,
  input  logic [NumLeds-1:0]     led_q_i,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumLeds - 1);
  localparam logic [IdxW:0]   NumLedsL = (IdxW + 1)'(NumLeds);

  led_state_e      state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic              can_accept;
  logic [NumReq-1:0] arb_req;
  logic [NumReq-1:0] gnt;
  logic [PtrW-1:0]   gnt_idx;
  logic              accept;
  logic [IdxW-1:0]   sel_idx;
  led_op_e           sel_op;
  logic              in_range;

  // Requests are only eligible in IDLE with no clear pending; a clear request
  // wins over writes in the same cycle. Gating with rst_ni keeps ready low
  // while reset is held.
  assign can_accept = rst_ni && (state_q == ST_IDLE) && !clear_i;
  assign arb_req    = req_valid_i & {NumReq{can_accept}};

  rr_arbiter #(
    .NumReq (NumReq)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (arb_req),
    .advance_i (accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign accept      = |gnt;

  // Select the winning requester's index and op.
  always_comb begin
    sel_idx = '0;
    sel_op  = OP_NOP;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (PtrW'(i) == gnt_idx) begin
        sel_idx = req_idx_i[i*IdxW +: IdxW];
        sel_op  = led_op_e'(req_op_i[2*i +: 2]);
      end
    end
  end

  // Only matters when NumLeds is not a power of two.
  assign in_range = {1'b0, sel_idx} < NumLedsL;

  // Next-state logic for the sweep FSM and its counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        // clear_i is ignored here; the sweep always runs to completion.
        if (cnt_q == LastIdx) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Cell enable/data decode. Disabled cells see d=0 so the shared data lines
  // stay quiet.
  always_comb begin
    led_en_o = '0;
    led_d_o  = '0;
    if (state_q == ST_CLEAR) begin
      led_en_o[cnt_q] = 1'b1;
    end else if (accept && in_range && op_writes(sel_op)) begin
      led_en_o[sel_idx] = 1'b1;
      led_d_o[sel_idx]  = op_data(sel_op, led_q_i[sel_idx]);
    end
  end

  // An accepted out-of-range index is dropped and flagged one cycle later.
  assign err_d  = accept && !in_range;
  assign err_o  = err_q;
  assign busy_o = (state_q == ST_CLEAR);

  // State, counter and error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
